// File: rtl/hilo_unit_pkg.sv
// rtl/hilo_unit_pkg.sv - shared constants and state encoding for the HI/LO unit
package hilo_unit_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int DIV_STEPS  = HILO_WIDTH;

  // Quotient reported for a zero divisor: all ones, no exception raised
  localparam logic [HILO_WIDTH-1:0] DIV_ZERO_QUO = {HILO_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_unit_seq_divider.sv
// rtl/hilo_unit_seq_divider.sv - iterative restoring divider datapath with sign fix-up
module hilo_unit_seq_divider
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             q_neg_q;
  logic             r_neg_q;
  logic             zero_q;
  logic [WIDTH-1:0] a_orig_q;
  logic [WIDTH-1:0] b_abs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   shift_w;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];

  // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
  // The shifted remainder is one bit wider so the compare never overflows.
  always_comb begin
    shift_w = {rem_q, quo_q[WIDTH-1]};
    ge      = (shift_w >= {1'b0, b_abs_q});
    rem_d   = ge ? WIDTH'(shift_w - {1'b0, b_abs_q}) : shift_w[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ge};
  end

  // Operand capture on start, then one step per cycle while stepping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      zero_q   <= 1'b0;
      a_orig_q <= '0;
      b_abs_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      zero_q   <= (b_i == '0);
      a_orig_q <= a_i;
      b_abs_q  <= b_neg ? -b_i : b_i;
      quo_q    <= a_neg ? -a_i : a_i;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = step_i && (cnt_q == CW'(DIV_STEPS - 1));
  assign quo_o  = zero_q ? DIV_ZERO_QUO : (q_neg_q ? -quo_q : quo_q);
  assign rem_o  = zero_q ? a_orig_q     : (r_neg_q ? -rem_q : rem_q);

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with write priority and sequential divide
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] ALUResultHI,
  input  logic             HiLoWrite,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             DivStart,
  input  logic             DivSigned,
  input  logic [WIDTH-1:0] DivA,
  input  logic [WIDTH-1:0] DivB,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             DivDone
);

  hilo_state_e      state_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             div_start;
  logic             div_step;
  logic             div_last;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign div_start = (state_q == IDLE) && DivStart;
  assign div_step  = (state_q == DIV);

  hilo_unit_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .start_i  (div_start),
    .step_i   (div_step),
    .signed_i (DivSigned),
    .a_i      (DivA),
    .b_i      (DivB),
    .last_o   (div_last),
    .quo_o    (div_quo),
    .rem_o    (div_rem)
  );

  // Control FSM: prioritised register writes in IDLE, divide sequencing otherwise
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (DivStart) begin
            state_q <= DIV;
          end else if (HiLoWrite) begin
            hi_q <= ALUResultHI;
            lo_q <= ALUResult;
          end else if (mthi) begin
            hi_q <= ALUResultHI;
          end else if (mtlo) begin
            lo_q <= ALUResult;
          end
        end
        DIV: begin
          if (div_last) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= div_rem;
          lo_q    <= div_quo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q != IDLE);
  assign DivDone = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking scoreboard bench for hilo_unit
module tb_hilo_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] ALUResult = '0;
  logic [31:0] ALUResultHI = '0;
  logic        HiLoWrite = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        DivStart = 1'b0;
  logic        DivSigned = 1'b0;
  logic [31:0] DivA = '0;
  logic [31:0] DivB = '0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        DivDone;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  hilo_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .ALUResult   (ALUResult),
    .ALUResultHI (ALUResultHI),
    .HiLoWrite   (HiLoWrite),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .DivStart    (DivStart),
    .DivSigned   (DivSigned),
    .DivA        (DivA),
    .DivB        (DivB),
    .HI          (HI),
    .LO          (LO),
    .Busy        (Busy),
    .DivDone     (DivDone)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic test_reset();
    n_checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || DivDone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: HI=%h LO=%h Busy=%b DivDone=%b, required all zero", HI, LO, Busy, DivDone);
    end
  endtask

  task automatic reg_write(input logic w, input logic h, input logic l,
                           input logic [31:0] vhi, input logic [31:0] vlo, input string name);
    logic [63:0] exp;
    if (w)      exp = {vhi, vlo};
    else if (h) exp = {vhi, lo_m};
    else if (l) exp = {hi_m, vlo};
    else        exp = {hi_m, lo_m};
    sb_q.push_back(exp);
    @(negedge Clk);
    HiLoWrite = w; mthi = h; mtlo = l; ALUResultHI = vhi; ALUResult = vlo;
    @(negedge Clk);
    HiLoWrite = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (HI !== exp[63:32] || LO !== exp[31:0]) begin
      n_fail++;
      $display("FAIL %s: HI=%h LO=%h, required HI=%h LO=%h", name, HI, LO, exp[63:32], exp[31:0]);
    end
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  task automatic test_hilowrite();
    reg_write(1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, "hilowrite");
    reg_write(1'b1, 1'b1, 1'b1, 32'h0BAD_F00D, 32'hC0FF_EE00, "hilowrite_priority");
  endtask

  task automatic test_mthi_mtlo();
    reg_write(1'b0, 1'b1, 1'b1, 32'hAAAA_5555, 32'h1234_5678, "mthi_mtlo_both");
    reg_write(1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 32'h1234_5678, "mtlo_only");
    reg_write(1'b0, 1'b1, 1'b0, 32'h0F0F_0F0F, 32'h9999_9999, "mthi_only");
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input string name);
    logic [63:0] exp;
    int busy_cnt;
    bit done_seen;
    sb_q.push_back(model_div(s, a, b));
    @(negedge Clk);
    DivSigned = s; DivA = a; DivB = b; DivStart = 1'b1;
    @(negedge Clk);
    DivStart = 1'b0;
    busy_cnt = 0;
    done_seen = 0;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      n_checks++;
      if (Busy && DivDone) begin
        n_fail++;
        $display("FAIL %s_busy_done_overlap: Busy=%b DivDone=%b, required not both high", name, Busy, DivDone);
      end
      if (Busy) begin
        busy_cnt++;
        n_checks++;
        if (HI !== hi_m || LO !== lo_m) begin
          n_fail++;
          $display("FAIL %s_hold: HI=%h LO=%h, required HI=%h LO=%h", name, HI, LO, hi_m, lo_m);
        end
        if (busy_cnt == inject_at) begin
          HiLoWrite = 1'b1; DivStart = 1'b1; mthi = 1'b1; mtlo = 1'b1;
          ALUResultHI = 32'hDEAD_BEEF; ALUResult = 32'hFEED_FACE;
          DivA = 32'd77; DivB = 32'd5;
        end else begin
          HiLoWrite = 1'b0; DivStart = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        end
      end
      if (DivDone) begin
        done_seen = 1;
        exp = sb_q.pop_front();
        n_checks++;
        if (HI !== exp[63:32] || LO !== exp[31:0]) begin
          n_fail++;
          $display("FAIL %s_result: HI=%h LO=%h, required HI=%h LO=%h", name, HI, LO, exp[63:32], exp[31:0]);
        end
        hi_m = exp[63:32];
        lo_m = exp[31:0];
      end else begin
        @(negedge Clk);
      end
    end
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s_timeout: no DivDone within 100 cycles, required DivDone", name);
      void'(sb_q.pop_front());
    end
    n_checks++;
    if (busy_cnt != 33) begin
      n_fail++;
      $display("FAIL %s_busy_len: Busy cycles=%0d, required 33", name, busy_cnt);
    end
    @(negedge Clk);
    n_checks++;
    if (DivDone !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: DivDone=%b Busy=%b, required 0 0", name, DivDone, Busy);
    end
  endtask

  task automatic test_divide();
    run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    n_checks++;
    if (LO !== 32'd14 || HI !== 32'd2) begin
      n_fail++;
      $display("FAIL divu_100_7_const: HI=%h LO=%h, required HI=00000002 LO=0000000e", HI, LO);
    end
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    n_checks++;
    if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL div_m7_2_const: HI=%h LO=%h, required HI=ffffffff LO=fffffffd", HI, LO);
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd3;
      run_div(k[0], a, b, 0, "div_random");
    end
  endtask

  task automatic test_corners();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
    n_checks++;
    if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      n_fail++;
      $display("FAIL div_overflow_const: HI=%h LO=%h, required HI=00000000 LO=80000000", HI, LO);
    end
    run_div(1'b0, 32'hCAFE_1234, 32'd1, 0, "divu_by_one");
    run_div(1'b0, 32'hF000_0001, 32'h8000_0000, 0, "divu_msb_divisor");
    run_div(1'b1, 32'h0000_0011, 32'hFFFF_FFFB, 0, "div_pos_neg");
    run_div(1'b0, 32'h0000_1234, 32'd0, 0, "div_by_zero");
    n_checks++;
    if (LO !== 32'hFFFF_FFFF || HI !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL div_by_zero_const: HI=%h LO=%h, required HI=00001234 LO=ffffffff", HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    run_div(1'b0, 32'd1000, 32'd3, 10, "ignore_while_busy");
    run_div(1'b1, 32'hFFFF_FC18, 32'd7, 0, "back_to_back");
  endtask

  task automatic test_async_reset();
    int stray;
    @(negedge Clk);
    DivSigned = 1'b0; DivA = 32'd5000; DivB = 32'd3; DivStart = 1'b1;
    @(negedge Clk);
    DivStart = 1'b0;
    repeat (19) @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    n_checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || DivDone !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: HI=%h LO=%h Busy=%b DivDone=%b, required all zero", HI, LO, Busy, DivDone);
    end
    #1 Rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    stray = 0;
    repeat (40) begin
      @(negedge Clk);
      if (DivDone || Busy) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL async_reset_no_done: stray Busy/DivDone cycles=%0d, required 0", stray);
    end
    run_div(1'b0, 32'd100, 32'd7, 0, "after_reset");
  endtask

  initial begin
    #12 Rst = 1'b0;
    @(negedge Clk);
    test_reset();
    test_hilowrite();
    test_mthi_mtlo();
    test_divide();
    test_corners();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
